// File: rtl/spi_slave_ram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_ram_bridge_if
// Brief    : Serial-side signal bundle between an SPI master and the RAM bridge.
// Revision : 1.0  initial release
// ============================================================================
interface spi_slave_ram_bridge_if;
    logic ss_n;
    logic mosi;
    logic miso;
    logic frame_err;

    modport master (
        output ss_n,
        output mosi,
        input  miso,
        input  frame_err
    );

    modport slave (
        input  ss_n,
        input  mosi,
        output miso,
        output frame_err
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_ram_bridge
// Brief    : Mode-0 SPI slave giving a serial master burst access to a word RAM
//            through command-loaded write/read pointers.
// Revision : 1.0  initial release
// ============================================================================
module spi_slave_ram_bridge #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 2**ADDR_W,
    parameter int AUTO_INC = 1
) (
    input  wire                    clk,
    input  wire                    rst_n,
    spi_slave_ram_bridge_if.slave  spi
);

    localparam int c_W_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int c_CNT_W = $clog2(c_W_MAX) + 1;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_CMD     = 3'd1;
    localparam logic [2:0] c_ST_ADDR_WR = 3'd2;
    localparam logic [2:0] c_ST_WDATA   = 3'd3;
    localparam logic [2:0] c_ST_ADDR_RD = 3'd4;
    localparam logic [2:0] c_ST_RDATA   = 3'd5;

    localparam logic [ADDR_W:0]   c_DEPTH    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(ADDR_W - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0]  r_mem [0:DEPTH-1];

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_cmd_hi;
    logic               r_addr_done;
    logic [ADDR_W-1:0]  r_ashift;
    logic [DATA_W-1:0]  r_wshift;
    logic [DATA_W-1:0]  r_rshift;
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic               r_miso;
    logic               r_frame_err;

    logic [ADDR_W-1:0]  w_ashift_nxt;
    logic [DATA_W-1:0]  w_wshift_nxt;
    logic [ADDR_W-1:0]  w_wr_next;
    logic [ADDR_W-1:0]  w_rd_next;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [DATA_W-1:0]  w_rd_word;
    logic               w_addr_last;
    logic               w_data_last;
    logic               w_partial;
    logic               w_mem_we;

    function automatic logic in_range(input logic [ADDR_W-1:0] p);
        return ({1'b0, p} < c_DEPTH);
    endfunction

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        if (AUTO_INC == 0)
            return p;
        else if (p == c_LAST_PTR)
            return '0;
        else
            return p + ADDR_W'(1);
    endfunction

    // Casts keep only the low bits, so the shifters stay legal for 1-bit widths.
    assign w_ashift_nxt = ADDR_W'({r_ashift, spi.mosi});
    assign w_wshift_nxt = DATA_W'({r_wshift, spi.mosi});
    assign w_wr_next    = next_ptr(r_wr_ptr);
    assign w_rd_next    = next_ptr(r_rd_ptr);
    assign w_addr_last  = (r_cnt == c_ADDR_LAST);
    assign w_data_last  = (r_cnt == c_DATA_LAST);

    // In RDATA the read port prefetches the word after the one being shifted out.
    assign w_rd_addr = (r_state == c_ST_RDATA) ? w_rd_next : r_rd_ptr;
    assign w_rd_word = in_range(w_rd_addr) ? r_mem[w_rd_addr] : '0;

    assign w_mem_we = rst_n && !spi.ss_n && (r_state == c_ST_WDATA) &&
                      w_data_last && in_range(r_wr_ptr);

    always_comb begin
        w_partial = 1'b0;
        case (r_state)
            c_ST_ADDR_WR, c_ST_ADDR_RD: w_partial = !r_addr_done && (r_cnt != '0);
            c_ST_WDATA,   c_ST_RDATA:   w_partial = (r_cnt != '0);
            default:                    w_partial = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[r_wr_ptr] <= w_wshift_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_cmd_hi    <= 1'b0;
            r_addr_done <= 1'b0;
            r_ashift    <= '0;
            r_wshift    <= '0;
            r_rshift    <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_miso      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (spi.ss_n) begin
                r_frame_err <= w_partial;
                r_state     <= c_ST_IDLE;
                r_cnt       <= '0;
                r_miso      <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_cmd_hi    <= spi.mosi;
                        r_cnt       <= '0;
                        r_addr_done <= 1'b0;
                        r_miso      <= 1'b0;
                        r_state     <= c_ST_CMD;
                    end
                    c_ST_CMD: begin
                        r_cnt  <= '0;
                        r_miso <= 1'b0;
                        case ({r_cmd_hi, spi.mosi})
                            2'b00: r_state <= c_ST_ADDR_WR;
                            2'b01: r_state <= c_ST_WDATA;
                            2'b10: r_state <= c_ST_ADDR_RD;
                            2'b11: begin
                                r_state  <= c_ST_RDATA;
                                r_rshift <= w_rd_word;
                            end
                        endcase
                    end
                    c_ST_ADDR_WR: begin
                        if (!r_addr_done) begin
                            r_ashift <= w_ashift_nxt;
                            if (w_addr_last) begin
                                r_wr_ptr    <= w_ashift_nxt;
                                r_addr_done <= 1'b1;
                                r_cnt       <= '0;
                            end else begin
                                r_cnt <= r_cnt + c_CNT_W'(1);
                            end
                        end
                    end
                    c_ST_ADDR_RD: begin
                        if (!r_addr_done) begin
                            r_ashift <= w_ashift_nxt;
                            if (w_addr_last) begin
                                r_rd_ptr    <= w_ashift_nxt;
                                r_addr_done <= 1'b1;
                                r_cnt       <= '0;
                            end else begin
                                r_cnt <= r_cnt + c_CNT_W'(1);
                            end
                        end
                    end
                    c_ST_WDATA: begin
                        r_wshift <= w_wshift_nxt;
                        if (w_data_last) begin
                            r_cnt    <= '0;
                            r_wr_ptr <= w_wr_next;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                    c_ST_RDATA: begin
                        r_miso <= r_rshift[DATA_W-1];
                        if (w_data_last) begin
                            r_cnt    <= '0;
                            r_rd_ptr <= w_rd_next;
                            r_rshift <= w_rd_word;
                        end else begin
                            r_cnt    <= r_cnt + c_CNT_W'(1);
                            r_rshift <= r_rshift << 1;
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        r_miso  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign spi.miso      = r_miso;
    assign spi.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_ram_bridge
// Brief    : Scoreboard bench for spi_slave_ram_bridge (full-depth and 200-deep).
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave_ram_bridge;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ss_n  = 1'b1;
    logic mosi  = 1'b0;
    int   sel   = 0;

    logic cap_en  = 1'b0;
    logic err_chk = 1'b0;
    logic done    = 1'b0;

    logic [7:0] exp_q[$];
    logic       err_q[$];

    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    int         cap_bits = 0;
    logic [7:0] cap_byte = '0;
    logic [7:0] exp_byte;
    logic       exp_fe;
    logic       miso_s;
    logic       fe_s;

    always #5 clk = ~clk;

    spi_slave_ram_bridge_if bus0 ();
    spi_slave_ram_bridge_if bus1 ();

    assign bus0.ss_n = ss_n | (sel != 0);
    assign bus0.mosi = mosi;
    assign bus1.ss_n = ss_n | (sel != 1);
    assign bus1.mosi = mosi;

    spi_slave_ram_bridge #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .AUTO_INC(1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .spi   (bus0)
    );

    spi_slave_ram_bridge #(.ADDR_W(8), .DATA_W(8), .DEPTH(200), .AUTO_INC(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .spi   (bus1)
    );

    // Monitor: owns every comparison and the counters.
    always begin
        @(posedge clk);
        #1;
        miso_s = (sel == 1) ? bus1.miso : bus0.miso;
        fe_s   = (sel == 1) ? bus1.frame_err : bus0.frame_err;
        if (bus0.frame_err === 1'b1) pulses++;
        if (bus1.frame_err === 1'b1) pulses++;
        if (cap_en) begin
            cap_byte = {cap_byte[6:0], miso_s};
            cap_bits++;
            if (cap_bits == 8) begin
                cap_bits = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_word unexpected got %h", cap_byte);
                end else begin
                    exp_byte = exp_q.pop_front();
                    if (cap_byte !== exp_byte) begin
                        errors++;
                        $display("FAIL rd_word dut%0d got %h exp %h", sel, cap_byte, exp_byte);
                    end
                end
            end
        end
        if (err_chk) begin
            checks++;
            if (err_q.size() == 0) begin
                errors++;
                $display("FAIL frame_end no expectation queued");
            end else begin
                exp_fe = err_q.pop_front();
                if (fe_s !== exp_fe || miso_s !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_end dut%0d frame_err=%b miso=%b exp frame_err=%b miso=0",
                             sel, fe_s, miso_s, exp_fe);
                end
            end
        end
        if (done) begin
            checks++;
            if (exp_q.size() != 0 || err_q.size() != 0) begin
                errors++;
                $display("FAIL leftover got %0d/%0d exp 0/0", exp_q.size(), err_q.size());
            end
            checks++;
            if (pulses != 2) begin
                errors++;
                $display("FAIL err_pulses got %0d exp 2", pulses);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // All tasks are entered and left on a negedge.
    task automatic zcheck(input logic fe);
        err_q.push_back(fe);
        err_chk = 1'b1;
        @(negedge clk);
        err_chk = 1'b0;
    endtask

    task automatic start_frame(input logic [1:0] cmd);
        ss_n = 1'b0;
        mosi = cmd[1];
        @(negedge clk);
        mosi = cmd[0];
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = v[i];
            @(negedge clk);
        end
    endtask

    task automatic end_frame(input logic fe);
        ss_n = 1'b1;
        mosi = 1'b0;
        zcheck(fe);
        @(negedge clk);
    endtask

    task automatic wr_addr(input logic [7:0] a);
        start_frame(2'b00); send_bits(a, 8); end_frame(1'b0);
    endtask

    task automatic rd_addr(input logic [7:0] a);
        start_frame(2'b10); send_bits(a, 8); end_frame(1'b0);
    endtask

    task automatic wr_data(input logic [7:0] b0, input logic [7:0] b1, input int n);
        start_frame(2'b01);
        send_bits(b0, 8);
        if (n > 1) send_bits(b1, 8);
        end_frame(1'b0);
    endtask

    task automatic rd_data(input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input int n);
        exp_q.push_back(e0);
        if (n > 1) exp_q.push_back(e1);
        if (n > 2) exp_q.push_back(e2);
        start_frame(2'b11);
        mosi   = 1'b0;
        cap_en = 1'b1;
        repeat (8 * n) @(negedge clk);
        cap_en = 1'b0;
        end_frame(1'b0);
    endtask

    initial begin
        // Reset: outputs quiet, then both pointers start at 0
        @(negedge clk);
        @(negedge clk);
        zcheck(1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        wr_data(8'h5A, 8'h00, 1);
        rd_data(8'h5A, 8'h00, 8'h00, 1);
        rd_addr(8'h00);
        rd_data(8'h5A, 8'h00, 8'h00, 1);

        // Burst write with auto-increment, pointer lands on 0x12
        wr_addr(8'h10);
        wr_data(8'hA5, 8'h3C, 2);
        wr_data(8'h77, 8'h00, 1);
        rd_addr(8'h10);
        rd_data(8'hA5, 8'h3C, 8'h77, 3);

        // Pointer wrap 0xFF -> 0x00
        wr_addr(8'hFF);
        wr_data(8'h11, 8'h22, 2);
        rd_addr(8'hFF);
        rd_data(8'h11, 8'h22, 8'h00, 2);

        // Aborted data word and aborted address leave RAM and pointers alone
        wr_addr(8'h20);
        wr_data(8'h66, 8'h00, 1);
        start_frame(2'b01); send_bits(8'hFF, 5); end_frame(1'b1);
        wr_data(8'h99, 8'h00, 1);
        rd_addr(8'h20);
        rd_data(8'h66, 8'h99, 8'h00, 2);
        start_frame(2'b01); end_frame(1'b0);
        start_frame(2'b11); end_frame(1'b0);
        start_frame(2'b00); send_bits(8'hAB, 3); end_frame(1'b1);
        wr_data(8'h5C, 8'h00, 1);
        rd_data(8'h5C, 8'h00, 8'h00, 1);

        // 200-deep instance: reset on the LSB edge suppresses the write
        sel = 1;
        @(negedge clk);
        wr_addr(8'h05);
        wr_data(8'hC3, 8'h3A, 2);
        wr_addr(8'h06);
        start_frame(2'b01);
        send_bits(8'hFF, 7);
        mosi  = 1'b1;
        rst_n = 1'b0;
        zcheck(1'b0);
        rst_n = 1'b1;
        ss_n  = 1'b1;
        zcheck(1'b0);
        @(negedge clk);
        rd_addr(8'h06);
        rd_data(8'h3A, 8'h00, 8'h00, 1);
        wr_data(8'h5E, 8'h00, 1);
        rd_addr(8'h00);
        rd_data(8'h5E, 8'h00, 8'h00, 1);

        // Out of range drops the write and reads zero; DEPTH-1 wraps to 0
        wr_addr(8'hF0);
        wr_data(8'hEE, 8'h00, 1);
        rd_addr(8'hF0);
        rd_data(8'h00, 8'h00, 8'h00, 1);
        wr_addr(8'hC7);
        wr_data(8'h44, 8'h55, 2);
        rd_addr(8'hC7);
        rd_data(8'h44, 8'h55, 8'h00, 2);

        repeat (2) @(negedge clk);
        done = 1'b1;
    end

endmodule
`default_nettype wire
